// File: rtl/jt5205_adpcm_mc.sv
// Multi-channel OKI/MSM5205-style ADPCM decoder. All channels share one serial
// shift-add datapath: a nibble is accepted in IDLE, multiplied by the channel's
// step size over 3 (4-bit) or 2 (3-bit) MUL cycles, then accumulated in UPD.
module jt5205_adpcm_mc #(
  parameter int CH   = 4,
  parameter int OW   = 12,
  parameter int REST = -2,
  parameter int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [CW-1:0]    din_ch,
  input  logic [3:0]       din,
  input  logic [CH-1:0]    mode,
  input  logic [CH-1:0]    clr,
  output logic             snd_valid,
  output logic [CW-1:0]    snd_ch,
  output logic [OW-1:0]    snd,
  output logic [CH*OW-1:0] snd_all
);

  localparam logic signed [OW-1:0] REST_V = OW'(REST);
  localparam logic signed [OW+1:0] SMAX   = (OW+2)'((2 ** (OW - 1)) - 1);
  localparam logic signed [OW+1:0] SMIN   = -(OW+2)'(2 ** (OW - 1));

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_UPD = 2'd2} state_t;

  // MSM5205 step table (12-bit scale)
  function automatic logic [10:0] step_tbl(input logic [5:0] i);
    case (i)
      6'd0:  step_tbl = 11'd16;   6'd1:  step_tbl = 11'd17;   6'd2:  step_tbl = 11'd19;
      6'd3:  step_tbl = 11'd21;   6'd4:  step_tbl = 11'd23;   6'd5:  step_tbl = 11'd25;
      6'd6:  step_tbl = 11'd28;   6'd7:  step_tbl = 11'd31;   6'd8:  step_tbl = 11'd34;
      6'd9:  step_tbl = 11'd37;   6'd10: step_tbl = 11'd41;   6'd11: step_tbl = 11'd45;
      6'd12: step_tbl = 11'd50;   6'd13: step_tbl = 11'd55;   6'd14: step_tbl = 11'd60;
      6'd15: step_tbl = 11'd66;   6'd16: step_tbl = 11'd73;   6'd17: step_tbl = 11'd80;
      6'd18: step_tbl = 11'd88;   6'd19: step_tbl = 11'd97;   6'd20: step_tbl = 11'd107;
      6'd21: step_tbl = 11'd118;  6'd22: step_tbl = 11'd130;  6'd23: step_tbl = 11'd143;
      6'd24: step_tbl = 11'd157;  6'd25: step_tbl = 11'd173;  6'd26: step_tbl = 11'd190;
      6'd27: step_tbl = 11'd209;  6'd28: step_tbl = 11'd230;  6'd29: step_tbl = 11'd253;
      6'd30: step_tbl = 11'd279;  6'd31: step_tbl = 11'd307;  6'd32: step_tbl = 11'd337;
      6'd33: step_tbl = 11'd371;  6'd34: step_tbl = 11'd408;  6'd35: step_tbl = 11'd449;
      6'd36: step_tbl = 11'd494;  6'd37: step_tbl = 11'd544;  6'd38: step_tbl = 11'd598;
      6'd39: step_tbl = 11'd658;  6'd40: step_tbl = 11'd724;  6'd41: step_tbl = 11'd796;
      6'd42: step_tbl = 11'd876;  6'd43: step_tbl = 11'd963;  6'd44: step_tbl = 11'd1060;
      6'd45: step_tbl = 11'd1166; 6'd46: step_tbl = 11'd1282; 6'd47: step_tbl = 11'd1411;
      default: step_tbl = 11'd1552;
    endcase
  endfunction

  state_t                 state_q;
  logic                   ready_q, valid_q, sign_q, drop_q;
  logic [1:0]             cnt_q;
  logic [2:0]             f_q;
  logic [OW:0]            q_q, d_q;
  logic [5:0]             nidx_q;
  logic [CW-1:0]          ch_q, snd_ch_q;
  logic signed [OW-1:0]   snd_q;
  logic [5:0]             idx_q [CH];
  logic signed [OW-1:0]   acc_q [CH];

  logic [5:0]             idx_in_d;
  logic                   mode_in_d, clr_in_d, clr_fly_d, ch_ok_d, upd_we_d;
  logic [OW:0]            step_d;
  logic signed [6:0]      nidx_raw_d;
  logic [5:0]             nidx_d;
  logic signed [OW-1:0]   acc_sel_d, acc_new_d;
  logic signed [OW+1:0]   sum_d, q_ext_d;

  // Channel lookups for the incoming nibble and for the nibble in flight
  always_comb begin
    idx_in_d  = 6'd0;
    mode_in_d = 1'b0;
    clr_in_d  = 1'b0;
    clr_fly_d = 1'b0;
    ch_ok_d   = 1'b0;
    acc_sel_d = REST_V;
    for (int c = 0; c < CH; c++) begin
      if (din_ch == CW'(c)) begin
        idx_in_d  = idx_q[c];
        mode_in_d = mode[c];
        clr_in_d  = clr[c];
      end
      if (ch_q == CW'(c)) begin
        clr_fly_d = clr[c];
        ch_ok_d   = 1'b1;
        acc_sel_d = acc_q[c];
      end
    end
  end

  // Step size and clamped next index for the incoming nibble
  always_comb begin
    step_d     = (OW+1)'(step_tbl(idx_in_d)) << (OW - 12);
    nidx_raw_d = $signed({1'b0, idx_in_d});
    if (mode_in_d) begin
      if (din[1]) nidx_raw_d = nidx_raw_d + (din[0] ? 7'sd4 : 7'sd2);
      else        nidx_raw_d = nidx_raw_d - 7'sd1;
    end else begin
      if (din[2]) begin
        case (din[1:0])
          2'd0:    nidx_raw_d = nidx_raw_d + 7'sd2;
          2'd1:    nidx_raw_d = nidx_raw_d + 7'sd4;
          2'd2:    nidx_raw_d = nidx_raw_d + 7'sd6;
          default: nidx_raw_d = nidx_raw_d + 7'sd8;
        endcase
      end else begin
        nidx_raw_d = nidx_raw_d - 7'sd1;
      end
    end
    if (nidx_raw_d < 7'sd0)       nidx_d = 6'd0;
    else if (nidx_raw_d > 7'sd48) nidx_d = 6'd48;
    else                          nidx_d = nidx_raw_d[5:0];
  end

  // Saturating accumulate of the finished product
  always_comb begin
    q_ext_d = $signed({1'b0, q_q});
    if (sign_q) sum_d = {{2{acc_sel_d[OW-1]}}, acc_sel_d} - q_ext_d;
    else        sum_d = {{2{acc_sel_d[OW-1]}}, acc_sel_d} + q_ext_d;
    if (sum_d > SMAX)      acc_new_d = SMAX[OW-1:0];
    else if (sum_d < SMIN) acc_new_d = SMIN[OW-1:0];
    else                   acc_new_d = sum_d[OW-1:0];
    upd_we_d = (state_q == ST_UPD) && ch_ok_d && !drop_q && !clr_fly_d;
  end

  // Sequencer FSM and shared shift-add datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      snd_q    <= REST_V;
      snd_ch_q <= '0;
      ch_q     <= '0;
      sign_q   <= 1'b0;
      drop_q   <= 1'b0;
      cnt_q    <= 2'd0;
      f_q      <= 3'd0;
      q_q      <= '0;
      d_q      <= '0;
      nidx_q   <= 6'd0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (din_valid && ready_q) begin
            state_q <= ST_MUL;
            ready_q <= 1'b0;
            ch_q    <= din_ch;
            d_q     <= step_d;
            nidx_q  <= nidx_d;
            drop_q  <= clr_in_d;
            if (mode_in_d) begin
              q_q    <= step_d >> 2;
              f_q    <= {din[1:0], 1'b0};
              sign_q <= din[2];
              cnt_q  <= 2'd2;
            end else begin
              q_q    <= step_d >> 3;
              f_q    <= din[2:0];
              sign_q <= din[3];
              cnt_q  <= 2'd3;
            end
          end
        end
        ST_MUL: begin
          if (f_q[2]) q_q <= q_q + d_q;
          d_q   <= d_q >> 1;
          f_q   <= {f_q[1:0], 1'b0};
          cnt_q <= cnt_q - 2'd1;
          if (clr_fly_d) drop_q <= 1'b1;
          if (cnt_q == 2'd1) state_q <= ST_UPD;
        end
        ST_UPD: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          if (upd_we_d) begin
            valid_q  <= 1'b1;
            snd_q    <= acc_new_d;
            snd_ch_q <= ch_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel index and sample state; clear wins over a same-edge update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        idx_q[c] <= 6'd0;
        acc_q[c] <= REST_V;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (clr[c]) begin
          idx_q[c] <= 6'd0;
          acc_q[c] <= REST_V;
        end else if (upd_we_d && (ch_q == CW'(c))) begin
          idx_q[c] <= nidx_q;
          acc_q[c] <= acc_new_d;
        end else begin
          idx_q[c] <= idx_q[c];
          acc_q[c] <= acc_q[c];
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_all
    assign snd_all[g*OW +: OW] = acc_q[g];
  end

  assign din_ready = ready_q;
  assign snd_valid = valid_q;
  assign snd_ch    = snd_ch_q;
  assign snd       = snd_q;

endmodule

// File: tb/tb_jt5205_adpcm_mc.sv
// Scoreboard bench for jt5205_adpcm_mc. CH=5 so that din_ch=5 is an
// out-of-range channel. Expected samples are hand-computed constants.
module tb_jt5205_adpcm_mc;

  localparam int CH = 5;
  localparam int OW = 12;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [CW-1:0]    din_ch = '0;
  logic [3:0]       din = 4'd0;
  logic [CH-1:0]    mode = '0;
  logic [CH-1:0]    clr = '0;
  logic             snd_valid;
  logic [CW-1:0]    snd_ch;
  logic signed [OW-1:0] snd;
  logic [CH*OW-1:0] snd_all;

  jt5205_adpcm_mc #(.CH(CH), .OW(OW), .REST(-2)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready),
    .din_ch(din_ch), .din(din), .mode(mode), .clr(clr),
    .snd_valid(snd_valid), .snd_ch(snd_ch), .snd(snd), .snd_all(snd_all)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int val; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int slice(input int c);
    logic signed [OW-1:0] v;
    v = snd_all[c*OW +: OW];
    return int'(v);
  endfunction

  task automatic push(input int ch, input int val);
    exp_t e;
    e.ch = ch;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a nibble; returns #1 after the accepting edge (E0)
  task automatic send(input int ch, input logic [3:0] code);
    int n;
    n = 0;
    din_valid = 1'b1;
    din_ch = CW'(ch);
    din = code;
    while (!din_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_wait", (n < 50) ? 0 : 1, 0);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    clr = '0;
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
  endtask

  // Monitor: every output pulse must match the oldest expected sample
  always @(negedge clk) begin
    if (!rst && snd_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_snd_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("snd", int'(snd), e.val);
        check("snd_ch", int'(snd_ch), e.ch);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, prev, n;
    // Reset state
    wait_cyc(2);
    check("rst_ready", int'(din_ready), 0);
    check("rst_valid", int'(snd_valid), 0);
    check("rst_snd", int'(snd), -2);
    check("rst_snd_ch", int'(snd_ch), 0);
    for (int c = 0; c < CH; c++) check("rst_snd_all", slice(c), -2);
    rst = 1'b0;
    wait_cyc(1);
    check("ready_after_rst", int'(din_ready), 1);

    // Test 1: 0000 on ch0, 5-cycle sequence, idx stays 0
    push(0, 0);
    send(0, 4'b0000);
    check("t1_ready_e0", int'(din_ready), 0);
    wait_cyc(3);
    check("t1_ready_e3", int'(din_ready), 0);
    wait_cyc(1);
    check("t1_ready_e4", int'(din_ready), 1);
    check("t1_all0", slice(0), 0);
    push(0, 30);
    send(0, 4'b0111);
    wait_cyc(5);

    // Test 2: 0111 twice from reset
    do_reset();
    push(0, 28);
    send(0, 4'b0111);
    wait_cyc(4);
    push(0, 91);
    send(0, 4'b0111);
    wait_cyc(5);
    check("t2_all0", slice(0), 91);

    // Test 3: positive then negative saturation
    do_reset();
    push(0, 28);   send(0, 4'b0111); wait_cyc(4);
    push(0, 91);   send(0, 4'b0111); wait_cyc(4);
    push(0, 227);  send(0, 4'b0111); wait_cyc(4);
    push(0, 520);  send(0, 4'b0111); wait_cyc(4);
    push(0, 1151); send(0, 4'b0111); wait_cyc(4);
    push(0, 2047); send(0, 4'b0111); wait_cyc(4);
    push(0, 2047); send(0, 4'b0111); wait_cyc(4);
    push(0, -863);  send(0, 4'b1111); wait_cyc(4);
    push(0, -2048); send(0, 4'b1111); wait_cyc(4);
    push(0, -2048); send(0, 4'b1111); wait_cyc(5);
    check("t3_all0", slice(0), -2048);

    // Test 4: 3-bit mode on ch1, din[3] ignored, mode change after accept ignored
    do_reset();
    mode = 5'b00010;
    push(1, 26);
    send(1, 4'b1011);
    wait_cyc(2);
    check("t4_ready_e2", int'(din_ready), 0);
    wait_cyc(1);
    check("t4_ready_e3", int'(din_ready), 1);
    push(1, 65);
    send(1, 4'b0011);
    mode = 5'b00000;
    wait_cyc(5);
    check("t4_all1", slice(1), 65);
    check("t4_all0", slice(0), -2);

    // Test 5: back-to-back with din_valid held; ch5 is out of range
    do_reset();
    prev = 0;
    din_valid = 1'b1;
    din_ch = 3'd0;
    din = 4'b0111;
    push(0, 28);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!din_ready && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("b2b_wait", (n < 50) ? 0 : 1, 0);
      @(posedge clk);
      #1;
      t = cyc;
      if (k > 0) check("b2b_gap", t - prev, 5);
      prev = t;
      case (k)
        0: begin din_ch = 3'd1; din = 4'b0001; push(1, 4); end
        1: begin din_ch = 3'd2; din = 4'b1010; push(2, -12); end
        2: begin din_ch = 3'd5; din = 4'b0111; end
        default: din_valid = 1'b0;
      endcase
    end
    wait_cyc(6);
    check("t5_all0", slice(0), 28);
    check("t5_all1", slice(1), 4);
    check("t5_all2", slice(2), -12);
    check("t5_all3", slice(3), -2);
    check("t5_all4", slice(4), -2);

    // Test 6: clr on the in-flight channel drops the update
    do_reset();
    push(0, 28);
    send(0, 4'b0111);
    wait_cyc(4);
    send(1, 4'b0111);
    wait_cyc(1);
    clr = 5'b00010;
    wait_cyc(1);
    clr = 5'b00000;
    wait_cyc(5);
    check("t6_all1", slice(1), -2);
    check("t6_all0", slice(0), 28);
    push(1, 28);
    send(1, 4'b0111);
    wait_cyc(4);
    // clr on a different channel leaves the operation alone
    push(0, 91);
    send(0, 4'b0111);
    wait_cyc(1);
    clr = 5'b00100;
    wait_cyc(1);
    clr = 5'b00000;
    wait_cyc(4);
    check("t6_all0b", slice(0), 91);
    // rst mid-operation
    send(0, 4'b0111);
    wait_cyc(1);
    #3 rst = 1'b1;
    wait_cyc(1);
    check("t6_rst_ready", int'(din_ready), 0);
    check("t6_rst_valid", int'(snd_valid), 0);
    check("t6_rst_snd", int'(snd), -2);
    check("t6_rst_snd_ch", int'(snd_ch), 0);
    check("t6_rst_all0", slice(0), -2);
    check("t6_rst_all1", slice(1), -2);
    rst = 1'b0;
    wait_cyc(10);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
